// File: rtl/pacote_sistema.sv
// Shared constants for the instruction fetch path: opcode values, instruction field
// positions and the fetch sequencer state encoding.
package pacote_sistema;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;

  localparam logic [4:0] OPCODE_HLT = 5'd18;
  localparam logic [4:0] OPCODE_LI  = 5'd25;

  typedef enum logic [1:0] {
    Ocioso,
    Executa,
    Parado,
    Erro
  } estado_t;

endpackage

// File: rtl/contador_de_programa.sv
// Program counter register: load has priority over increment, otherwise it holds.
module contador_de_programa #(
  parameter logic [31:0] PC_INICIAL = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        carregar,
  input  logic        incrementar,
  input  logic [31:0] valor,
  output logic [31:0] pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= PC_INICIAL;
    end else if (carregar) begin
      pc <= valor;
    end else if (incrementar) begin
      pc <= pc + 32'd1;
    end
  end

endmodule

// File: rtl/controle_de_busca.sv
// Instruction fetch sequencer: loads the program into instruction memory, then fetches
// into the instruction register, honouring stall, branch and hlt.
module controle_de_busca #(
  parameter int unsigned PROFUNDIDADE = 32,
  parameter logic [31:0] PC_INICIAL   = 32'd1,
  parameter logic [4:0]  OPCODE_HLT   = pacote_sistema::OPCODE_HLT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        carga_valida,
  input  logic [31:0] carga_dado,
  input  logic        carga_fim,
  output logic        carga_pronto,
  output logic        mem_escrita,
  output logic [31:0] mem_endereco_escrita,
  output logic [31:0] mem_dado_escrita,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  input  logic        espera,
  input  logic        desvio,
  input  logic [31:0] destino,
  output logic [31:0] ir,
  output logic        ir_valido,
  output logic        parado,
  output logic        erro
);
  import pacote_sistema::*;

  localparam logic [31:0] LIMITE = 32'(PROFUNDIDADE);

  estado_t     estado_q;
  logic [31:0] ponteiro_q;
  logic [31:0] ir_q;
  logic        ir_valido_q;
  logic        parado_q;
  logic        erro_q;

  logic [31:0] pc;
  logic [31:0] pc_valor;
  logic        pc_carregar;
  logic        pc_incrementar;
  logic        pc_fora;
  logic        ponteiro_fora;
  logic        e_hlt;

  assign pc_fora       = pc >= LIMITE;
  assign ponteiro_fora = ponteiro_q >= LIMITE;
  assign e_hlt         = instrucao[OPCODE_MSB:OPCODE_LSB] == OPCODE_HLT;

  contador_de_programa #(
    .PC_INICIAL(PC_INICIAL)
  ) u_contador_de_programa (
    .clock      (clock),
    .reset      (reset),
    .carregar   (pc_carregar),
    .incrementar(pc_incrementar),
    .valor      (pc_valor),
    .pc         (pc)
  );

  // PC moves only on a real fetch; hlt and out-of-range fetches leave it in place.
  always_comb begin
    pc_carregar    = 1'b0;
    pc_incrementar = 1'b0;
    pc_valor       = PC_INICIAL;
    unique case (estado_q)
      Ocioso:  pc_carregar = iniciar && !carga_valida;
      Executa: begin
        if (desvio) begin
          pc_carregar = 1'b1;
          pc_valor    = destino;
        end else if (!espera && !pc_fora && !e_hlt) begin
          pc_incrementar = 1'b1;
        end
      end
      Parado:  pc_carregar = iniciar;
      Erro:    ;
    endcase
  end

  assign carga_pronto         = estado_q == Ocioso;
  assign mem_escrita          = (estado_q == Ocioso) && carga_valida && !ponteiro_fora;
  assign mem_endereco_escrita = ponteiro_q;
  assign mem_dado_escrita     = carga_dado;
  assign endereco             = pc;
  assign ir                   = ir_q;
  assign ir_valido            = ir_valido_q;
  assign parado               = parado_q;
  assign erro                 = erro_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= Ocioso;
      ponteiro_q  <= PC_INICIAL;
      ir_q        <= 32'd0;
      ir_valido_q <= 1'b0;
      parado_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      unique case (estado_q)
        Ocioso: begin
          if (carga_valida) begin
            if (ponteiro_fora) begin
              estado_q <= Erro;
              erro_q   <= 1'b1;
            end else begin
              ponteiro_q <= carga_fim ? PC_INICIAL : ponteiro_q + 32'd1;
            end
          end else if (iniciar) begin
            estado_q <= Executa;
          end
        end
        Executa: begin
          if (desvio) begin
            ir_valido_q <= 1'b0;
          end else if (!espera) begin
            if (pc_fora) begin
              ir_valido_q <= 1'b0;
              estado_q    <= Erro;
              erro_q      <= 1'b1;
            end else begin
              ir_q        <= instrucao;
              ir_valido_q <= 1'b1;
              if (e_hlt) begin
                estado_q <= Parado;
                parado_q <= 1'b1;
              end
            end
          end
        end
        Parado: begin
          ir_valido_q <= 1'b0;
          if (iniciar) begin
            estado_q <= Executa;
            parado_q <= 1'b0;
          end
        end
        Erro: ir_valido_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_de_busca.sv
// Bench for controle_de_busca: a behavioural instruction memory plus a program-order
// scoreboard for the fetch stream, with directed load, stall, branch and fault steps.
module tb_controle_de_busca;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic        carga_valida;
  logic [31:0] carga_dado;
  logic        carga_fim;
  logic        carga_pronto;
  logic        mem_escrita;
  logic [31:0] mem_endereco_escrita;
  logic [31:0] mem_dado_escrita;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic        espera;
  logic        desvio;
  logic [31:0] destino;
  logic [31:0] ir;
  logic        ir_valido;
  logic        parado;
  logic        erro;

  logic [31:0] mem [0:31];
  logic [31:0] prog [1:6];
  logic [31:0] grande [1:31];
  logic [31:0] prev_ir;
  logic        prev_v;
  logic [31:0] pc_m;
  logic [31:0] alvo;
  logic        halted;
  int          tests;
  int          fails;

  controle_de_busca u_dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .carga_valida        (carga_valida),
    .carga_dado          (carga_dado),
    .carga_fim           (carga_fim),
    .carga_pronto        (carga_pronto),
    .mem_escrita         (mem_escrita),
    .mem_endereco_escrita(mem_endereco_escrita),
    .mem_dado_escrita    (mem_dado_escrita),
    .endereco            (endereco),
    .instrucao           (instrucao),
    .espera              (espera),
    .desvio              (desvio),
    .destino             (destino),
    .ir                  (ir),
    .ir_valido           (ir_valido),
    .parado              (parado),
    .erro                (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_escrita) mem[mem_endereco_escrita[4:0]] <= mem_dado_escrita;
  end

  assign instrucao = (endereco < 32'd32) ? mem[endereco[4:0]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] palavra_comum();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'd18) w[31:27] = 5'd25;
    return w;
  endfunction

  task automatic carrega(input logic [31:0] w, input logic fim, input logic [31:0] addr,
                         input logic ini);
    carga_valida = 1'b1;
    carga_dado   = w;
    carga_fim    = fim;
    iniciar      = ini;
    #1;
    check("carga_pronto", 32'(carga_pronto), 32'd1);
    check("mem_escrita", 32'(mem_escrita), 32'd1);
    check("end_escrita", mem_endereco_escrita, addr);
    check("dado_escrita", mem_dado_escrita, w);
    tick();
    carga_valida = 1'b0;
    carga_fim    = 1'b0;
    iniciar      = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    reset = 1'b1; iniciar = 1'b0; carga_valida = 1'b0; carga_dado = 32'd0;
    carga_fim = 1'b0; espera = 1'b0; desvio = 1'b0; destino = 32'd0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ir", ir, 32'd0);
    check("rst_ir_valido", 32'(ir_valido), 32'd0);
    check("rst_parado", 32'(parado), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_endereco", endereco, 32'd1);
    check("rst_carga_pronto", 32'(carga_pronto), 32'd1);
    check("rst_mem_escrita", 32'(mem_escrita), 32'd0);

    // Five-word load, then a six-word load that must start again at address 1
    for (int i = 1; i <= 5; i++) carrega(palavra_comum(), i == 5, 32'(i), 1'b0);
    for (int i = 1; i <= 5; i++) prog[i] = palavra_comum();
    prog[6] = {5'd18, 27'd0};
    for (int i = 1; i <= 6; i++) begin
      carrega(prog[i], i == 6, 32'(i), i == 3);
      if (i == 3) check("iniciar_ignorado", 32'(carga_pronto), 32'd1);
    end
    check("mem6", mem[6], prog[6]);

    // Run with random stalls plus a forced 3-cycle stall; deliveries follow program order
    pc_m = 32'd1;
    halted = 1'b0;
    iniciar = 1'b1;
    #1;
    check("inicio_endereco", endereco, 32'd1);
    tick();
    iniciar = 1'b0;
    check("inicio_ir_valido", 32'(ir_valido), 32'd0);
    for (int c = 0; c < 60 && !halted; c++) begin
      espera = (c >= 3 && c <= 5) || ($urandom_range(0, 3) == 0);
      #1;
      check("endereco_run", endereco, pc_m);
      prev_ir = ir;
      prev_v  = ir_valido;
      tick();
      if (espera) begin
        check("espera_ir", ir, prev_ir);
        check("espera_valido", 32'(ir_valido), 32'(prev_v));
        check("espera_pc", endereco, pc_m);
      end else begin
        check("fetch_valido", 32'(ir_valido), 32'd1);
        check("fetch_ir", ir, prog[pc_m]);
        if (prog[pc_m][31:27] == 5'd18) begin
          halted = 1'b1;
          check("hlt_parado", 32'(parado), 32'd1);
          check("hlt_pc", endereco, pc_m);
        end else begin
          pc_m = pc_m + 32'd1;
        end
      end
    end
    espera = 1'b0;
    check("halt_reached", 32'(halted), 32'd1);
    tick();
    check("parado_hold", 32'(parado), 32'd1);
    check("parado_ir_valido", 32'(ir_valido), 32'd0);
    check("parado_pc", endereco, 32'd6);

    // Restart from hlt
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("restart_parado", 32'(parado), 32'd0);
    check("restart_pc", endereco, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("refetch_ir", ir, prog[i]);
    end

    // Branch taken while hlt sits at PC: no halt, one bubble
    alvo = 32'($urandom_range(1, 5));
    check("pc_no_hlt", endereco, 32'd6);
    desvio = 1'b1;
    destino = alvo;
    tick();
    desvio = 1'b0;
    check("desvio_parado", 32'(parado), 32'd0);
    check("desvio_bolha", 32'(ir_valido), 32'd0);
    check("desvio_pc", endereco, alvo);
    tick();
    check("desvio_alvo_valido", 32'(ir_valido), 32'd1);
    check("desvio_alvo_ir", ir, prog[alvo]);
    check("desvio_pc_inc", endereco, alvo + 32'd1);

    // Branch out of range, with a simultaneous stall that must lose to the branch
    desvio = 1'b1;
    espera = 1'b1;
    destino = 32'd40;
    tick();
    desvio = 1'b0;
    espera = 1'b0;
    check("fora_bolha", 32'(ir_valido), 32'd0);
    check("fora_pc", endereco, 32'd40);
    check("fora_erro_ainda", 32'(erro), 32'd0);
    tick();
    check("fora_erro", 32'(erro), 32'd1);
    check("fora_ir_valido", 32'(ir_valido), 32'd0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("erro_pegajoso", 32'(erro), 32'd1);
    check("erro_carga_pronto", 32'(carga_pronto), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_erro", 32'(erro), 32'd0);
    check("reset_carga_pronto", 32'(carga_pronto), 32'd1);
    check("reset_pc", endereco, 32'd1);

    // Overfilling the memory: the word at pointer 32 is refused and faults
    for (int i = 1; i <= 31; i++) begin
      grande[i] = $urandom;
      carrega(grande[i], 1'b0, 32'(i), 1'b0);
    end
    carga_valida = 1'b1;
    carga_dado = $urandom;
    #1;
    check("cheio_pronto", 32'(carga_pronto), 32'd1);
    check("cheio_sem_escrita", 32'(mem_escrita), 32'd0);
    tick();
    carga_valida = 1'b0;
    check("cheio_erro", 32'(erro), 32'd1);
    check("cheio_carga_pronto", 32'(carga_pronto), 32'd0);
    check("mem_1", mem[1], grande[1]);
    check("mem_31", mem[31], grande[31]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
